// File: rtl/pg_pipe_buffer.sv
// Elastic P/G register pipeline between Kogge-Stone prefix levels: STAGES cycles latency, 1 pair/cycle.
// Backpressure: empty slots always load (bubbles collapse); in_ready drops only when every slot is full and out_ready is low.
module pg_pipe_buffer #(
  parameter int  WIDTH  = 16,
  parameter int  STAGES = 2,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  p [STAGES];
  logic [WIDTH-1:0]  g [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_nxt;
  logic              in_xfer;

  // A slot may advance if any slot at or downstream of it is empty, or the sink drains.
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    assign adv[i] = out_ready | ~(&v[STAGES-1:i]);
  end

  assign in_ready = adv[0] & ~rst;
  assign in_xfer  = in_valid & in_ready;

  assign v_nxt[0] = adv[0] ? in_xfer : v[0];
  assign load[0]  = adv[0] & in_xfer;

  for (genvar i = 1; i < STAGES; i++) begin : g_slot
    assign v_nxt[i] = adv[i] ? v[i-1] : v[i];
    assign load[i]  = adv[i] & v[i-1];
  end

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v     <= '0;
      occ_q <= '0;
    end else begin
      v     <= v_nxt;
      occ_q <= occ_nxt;
    end
  end

  // Payload only moves with a valid source, so stale data holds rather than shifting bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        p[i] <= '0;
        g[i] <= '0;
      end
    end else if (!flush) begin
      if (load[0]) begin
        p[0] <= in_p;
        g[0] <= in_g;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          p[i] <= p[i-1];
          g[i] <= g[i-1];
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_p     = p[STAGES-1];
  assign out_g     = g[STAGES-1];
  assign occupancy = occ_q;

endmodule
